// File: rtl/cpu_mulx_sequencer_if.sv
// Request/result handshake bundle between the CPU extended-multiply path and the
// 32x32 multiply sequencer.
interface cpu_mulx_sequencer_if;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sign_a;
    logic        sign_b;
    logic        ready;
    logic        busy;
    logic [63:0] result;
    logic        result_valid;
    logic        result_ack;

    modport master (
        output start, src1, src2, sign_a, sign_b, result_ack,
        input  ready, busy, result, result_valid
    );

    modport slave (
        input  start, src1, src2, sign_a, sign_b, result_ack,
        output ready, busy, result, result_valid
    );
endinterface

// File: rtl/cpu_mulx_sequencer.sv
// 32x32 -> 64 multiply built from four 16x16 unsigned partial products through one
// shared registered multiplier cell, followed by a two's-complement correction step.
module cpu_mulx_sequencer #(
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned RESULT_W    = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_mulx_sequencer_if.slave  bus
);
    localparam int unsigned OP_W    = 32;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned PROD_W  = 32;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SHIFT_W = 2;
    localparam int unsigned LAST    = MUL_LATENCY - 1;
    localparam logic [MUL_LATENCY-1:0] LAST_ONLY = MUL_LATENCY'(1) << LAST;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]    idx_q;
    logic [OP_W-1:0]     a_q, b_q;
    logic                sa_q, sb_q;
    logic [RESULT_W-1:0] acc_q;
    logic [RESULT_W-1:0] result_q;
    logic                ready_q, busy_q, valid_q;

    logic [HALF_W-1:0]   op_a_c, op_b_c;
    logic [SHIFT_W-1:0]  tag_c;
    logic [RESULT_W-1:0] addend_c;
    logic [RESULT_W-1:0] corr_a_c, corr_b_c, acc_fix_c;
    logic                accept_c;
    logic                drain_done_c;

    // Multiplier cell: stage 0 registers the product, later stages only delay it.
    logic [PROD_W-1:0]      prod_q [MUL_LATENCY];
    logic [SHIFT_W-1:0]     tag_q  [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] vld_q;

    assign accept_c     = (state_q == S_IDLE) && bus.start;
    assign drain_done_c = (vld_q == LAST_ONLY);

    // Half-word pair and shift tag (units of 16 bits) for the current issue slot.
    always_comb begin
        op_a_c = a_q[HALF_W-1:0];
        op_b_c = b_q[HALF_W-1:0];
        tag_c  = SHIFT_W'(0);
        case (idx_q)
            2'd1: begin
                op_a_c = a_q[OP_W-1:HALF_W];
                tag_c  = SHIFT_W'(1);
            end
            2'd2: begin
                op_b_c = b_q[OP_W-1:HALF_W];
                tag_c  = SHIFT_W'(1);
            end
            2'd3: begin
                op_a_c = a_q[OP_W-1:HALF_W];
                op_b_c = b_q[OP_W-1:HALF_W];
                tag_c  = SHIFT_W'(2);
            end
            default: ;
        endcase
    end

    always_comb begin
        addend_c = RESULT_W'(prod_q[LAST]);
        case (tag_q[LAST])
            2'd1:    addend_c = RESULT_W'(prod_q[LAST]) << 16;
            2'd2:    addend_c = RESULT_W'(prod_q[LAST]) << 32;
            default: ;
        endcase
    end

    // Unsigned product minus 2^32 * (other operand) for each negative signed operand.
    always_comb begin
        corr_a_c  = (sa_q && a_q[OP_W-1]) ? RESULT_W'({b_q, OP_W'(0)}) : RESULT_W'(0);
        corr_b_c  = (sb_q && b_q[OP_W-1]) ? RESULT_W'({a_q, OP_W'(0)}) : RESULT_W'(0);
        acc_fix_c = acc_q - corr_a_c - corr_b_c;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)       state_d = S_ISSUE;
            S_ISSUE: if (idx_q == 2'd3)   state_d = S_DRAIN;
            S_DRAIN: if (drain_done_c)    state_d = S_FIX;
            S_FIX:                        state_d = S_DONE;
            S_DONE:  if (bus.result_ack)  state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            vld_q[0]  <= (state_q == S_ISSUE);
            prod_q[0] <= PROD_W'(op_a_c) * PROD_W'(op_b_c);
            tag_q[0]  <= tag_c;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q   <= bus.src1;
                b_q   <= bus.src2;
                sa_q  <= bus.sign_a;
                sb_q  <= bus.sign_b;
                idx_q <= '0;
                acc_q <= '0;
            end else if (vld_q[LAST]) begin
                acc_q <= acc_q + addend_c;
            end
            if (state_q == S_ISSUE) idx_q    <= idx_q + IDX_W'(1);
            if (state_q == S_FIX)   result_q <= acc_fix_c;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            valid_q <= (state_d == S_DONE);
        end
    end

    assign bus.ready        = ready_q;
    assign bus.busy         = busy_q;
    assign bus.result       = 64'(result_q);
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_cpu_mulx_sequencer.sv
// Directed-vector bench for cpu_mulx_sequencer: products, latency, handshake, reset abort.
module tb_cpu_mulx_sequencer;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    cpu_mulx_sequencer_if bus();

    cpu_mulx_sequencer #(.MUL_LATENCY(1), .RESULT_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    task automatic ack_result(input string tag);
        @(negedge clk);
        bus.result_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ack = 1'b0;
        check({tag, "/ack_valid"}, 64'(bus.result_valid), 64'd0);
        check({tag, "/ack_ready"}, 64'(bus.ready), 64'd1);
        check({tag, "/ack_busy"},  64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp,
                          input bit do_ack);
        int n;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/ready"}, 64'(bus.ready), 64'd1);
        @(negedge clk);
        bus.src1   = a;
        bus.src2   = b;
        bus.sign_a = sa;
        bus.sign_b = sb;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.src1   = ~a;
        bus.src2   = b ^ 32'h1234_5678;
        bus.sign_a = ~sa;
        bus.sign_b = ~sb;
        check({tag, "/busy"}, 64'({bus.busy, bus.ready}), 64'b10);
        n = 0;
        while (!bus.result_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/latency"}, 64'(n), 64'd6);
        check({tag, "/result"}, bus.result, exp);
        if (do_ack) ack_result(tag);
    endtask

    initial begin
        logic [63:0] held;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.src1       = '0;
        bus.src2       = '0;
        bus.sign_a     = 1'b0;
        bus.sign_b     = 1'b0;
        bus.result_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/ready", 64'(bus.ready), 64'd1);
        check("rst/busy",  64'(bus.busy), 64'd0);
        check("rst/valid", 64'(bus.result_valid), 64'd0);
        check("rst/result", bus.result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Stray ack outside DONE must do nothing.
        @(negedge clk);
        bus.result_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ack = 1'b0;
        check("stray_ack/ready", 64'(bus.ready), 64'd1);

        run_op("umax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        run_op("smm1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
        run_op("mixed", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, 1'b1);
        run_op("mixb",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001, 1'b1);
        run_op("smin",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        run_op("carry", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        run_op("xhalf", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        run_op("neg3",  32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);

        // Hold the result unacknowledged while hammering start.
        run_op("hold", 32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0001_2345_6780, 1'b0);
        held = bus.result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = (i % 2) == 0;
            bus.src1  = 32'(i + 1);
            bus.src2  = 32'(i + 7);
            @(posedge clk);
            #1;
            check("hold/result", bus.result, 64'h0000_0001_2345_6780);
            check("hold/state",  64'({bus.result_valid, bus.ready, bus.busy}), 64'b101);
        end
        bus.start = 1'b0;
        ack_result("hold");
        check("hold/kept", bus.result, held);
        run_op("b2b", 32'h0000_0064, 32'h0000_0064, 1'b0, 1'b0, 64'd10000, 1'b1);

        // Abort during issue slot 2.
        @(negedge clk);
        bus.src1  = 32'hDEAD_BEEF;
        bus.src2  = 32'hCAFE_F00D;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort/ready",  64'(bus.ready), 64'd1);
        check("abort/busy",   64'(bus.busy), 64'd0);
        check("abort/valid",  64'(bus.result_valid), 64'd0);
        check("abort/result", bus.result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post", 32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
